// File: rtl/imem_loader_pkg.sv
// Shared CPU package: instruction-memory widths, the write-port payload and the
// boot loader state encoding.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W    = 32;
  localparam int unsigned IMEM_DATA_W    = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = IMEM_DATA_W / BYTE_W;
  localparam int unsigned LEN_W          = 16;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] data;
  } imem_wr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if
  import imem_loader_pkg::*;
();

  logic                   in_valid;
  logic [BYTE_W-1:0]      in_byte;
  logic                   in_ready;
  logic                   wr_en;
  logic [IMEM_ADDR_W-1:0] wr_addr;
  logic [IMEM_DATA_W-1:0] wr_data;

  // Stream source / memory sink side
  modport master (
    output in_valid, in_byte,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  // Loader side
  modport slave (
    input  in_valid, in_byte,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into instruction words; flags the byte
// that completes a word and presents the full word combinationally with it.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   accept,
  input  logic [BYTE_W-1:0]      byte_in,
  output logic                   word_done_c,
  output logic [IMEM_DATA_W-1:0] word_c
);

  localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned SREG_W = IMEM_DATA_W - BYTE_W;

  logic [IDX_W-1:0]  byte_idx;
  logic [SREG_W-1:0] sreg;

  // Earlier bytes shift down so the first byte ends up in the low lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      sreg     <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      sreg     <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + IDX_W'(1);
      sreg     <= {byte_in, sreg[SREG_W-1:BYTE_W]};
    end
  end

  assign word_done_c = accept && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word_c      = {byte_in, sreg};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it word by word
// into instruction memory and holds the CPU in reset until the image is in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned            MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  loader_state_e          state_q, state_d;
  logic [BYTE_W-1:0]      len_lo_q, len_lo_d;
  logic [LEN_W-1:0]       length_q, length_d;
  logic [LEN_W-1:0]       word_cnt_q, word_cnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   wr_en_q, wr_en_d;
  imem_wr_t               wr_q, wr_d;
  logic                   done_d, error_d, cpu_hold_d;

  logic                   xfer_c;
  logic                   packer_clr_c;
  logic                   word_done_c;
  logic [IMEM_DATA_W-1:0] word_c;
  logic [LEN_W-1:0]       len_c;

  assign xfer_c = bus.in_valid && in_ready_q;
  assign len_c  = {bus.in_byte, len_lo_q};

  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr         (packer_clr_c),
    .accept      (xfer_c && (state_q == ST_DATA)),
    .byte_in     (bus.in_byte),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      length_q   <= '0;
      word_cnt_q <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_q       <= '{addr: BASE_ADDR, data: '0};
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      length_q   <= length_d;
      word_cnt_q <= word_cnt_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_q       <= wr_d;
      cpu_hold   <= cpu_hold_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Next state; output levels follow the state being entered
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    length_d     = length_q;
    word_cnt_d   = word_cnt_q;
    wr_en_d      = 1'b0;
    wr_d         = wr_q;
    packer_clr_c = 1'b0;
    in_ready_d   = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    cpu_hold_d   = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d      = ST_LEN_LO;
          word_cnt_d   = '0;
          packer_clr_c = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (xfer_c) begin
          len_lo_d = bus.in_byte;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer_c) begin
          length_d = len_c;
          if (len_c == '0)          state_d = ST_DONE;
          else if (len_c > MAX_LEN) state_d = ST_ERROR;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The write cycle accepts no byte; leave only once the last word is out
        if (wr_en_q) begin
          if (word_cnt_q == length_q) state_d = ST_DONE;
        end else if (word_done_c) begin
          wr_en_d    = 1'b1;
          wr_d.addr  = BASE_ADDR + IMEM_ADDR_W'({word_cnt_q, 2'b00});
          wr_d.data  = word_c;
          word_cnt_d = word_cnt_q + LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = ((state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                  (state_d == ST_DATA)) && !wr_en_d;
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_q.addr;
  assign bus.wr_data  = wr_q.data;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-002 Parameter MAX_WORDS, default 256, largest accepted image length in 32-bit words (1..65535).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_byte  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high on a rising edge.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  32  instruction-memory byte address, word-aligned.
REQ-011 wr_data  output  32  instruction-memory write word.
REQ-012 cpu_hold  output  1  holds the CPU program counter and register file in reset while high.
REQ-013 done  output  1  level; image loaded successfully.
REQ-014 error  output  1  level; image rejected.

Function
REQ-015 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, DONE and ERROR.
REQ-016 IDLE: in_ready=0, cpu_hold=1; start SHALL move the FSM to LEN_LO and clear the word counter and byte index.
REQ-017 LEN_LO/LEN_HI: in_ready=1; the first byte SHALL be length[7:0] and the second SHALL be length[15:8].
REQ-018 After LEN_HI, length==0 SHALL go to DONE, length>MAX_WORDS SHALL go to ERROR, and any other length SHALL go to DATA.
REQ-019 DATA SHALL assemble bytes little-endian: byte index 0 maps to [7:0] and byte index 3 maps to [31:24].
REQ-020 On the cycle after the 4th byte of a word is accepted, the block SHALL pulse wr_en for exactly one cycle with wr_data = assembled word and wr_addr = BASE_ADDR + 4*word_index.
REQ-021 in_ready SHALL be 0 during the wr_en cycle, so the sustained rate is at most 4 bytes per 5 cycles.
REQ-022 in_valid gaps SHALL stall assembly without losing partial bytes, and in_byte SHALL be ignored when the transfer condition is false.
REQ-023 After the wr_en of word length-1, the FSM SHALL enter DONE.
REQ-024 DONE SHALL drive done=1, cpu_hold=0 and in_ready=0.
REQ-025 ERROR SHALL drive error=1, cpu_hold=1 and in_ready=0; no writes SHALL occur in ERROR.
REQ-026 start in DONE or ERROR SHALL restart at LEN_LO, clear done and error the next cycle, and raise cpu_hold the next cycle.
REQ-027 start SHALL be ignored in LEN_LO, LEN_HI and DATA.
REQ-028 The word counter SHALL be 16 bits and wr_addr arithmetic SHALL be 32-bit modulo 2^32; an address wrap is not flagged.
REQ-029 wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-030 Asserting rst low SHALL force the state to IDLE immediately, including in the middle of a load.
REQ-031 Reset values SHALL be: in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, error=0, counters=0.
REQ-032 A partially assembled word SHALL be discarded on reset and never written.
REQ-033 Reset deassertion is synchronized externally; the block SHALL first act on the clock edge after rst goes high.

Structure
REQ-034 The state encoding typedef and the 4-byte-per-word constant SHALL live in the shared CPU package alongside the instruction-memory width constants.
REQ-035 One sub-module, imem_word_packer (byte index, shift register, word-complete flag), SHALL be instantiated; all other logic SHALL be in imem_loader.
REQ-036 The block SHALL connect wr_* to the instruction-memory write port, and cpu_hold SHALL be ORed into the CPU top-level reset.

Verification
REQ-037 Reset, start, then bytes 02 00 13 00 50 00 B3 00 A0 00 -> wr_en at addr 0x0 with data 0x00500013, wr_en at addr 0x4 with data 0x00A000B3, then done=1 and cpu_hold=0.
REQ-038 Length bytes 00 00 -> DONE directly, with no wr_en pulse.
REQ-039 With MAX_WORDS=256, length bytes 01 01 (257) -> error=1, cpu_hold=1, and no wr_en.
REQ-040 One-word image with in_valid toggled every other cycle -> a single write of the correct word, with in_ready=0 during the wr_en cycle.
REQ-041 rst asserted after 2 data bytes, then start and a fresh 1-word image -> only the fresh word is written, at BASE_ADDR.
REQ-042 start pulse issued in DATA -> ignored; start issued in ERROR -> error clears and a reload succeeds.
